// File: rtl/ereg_ctrl.sv
// Decode->Execute pipeline register for the five-stage Y86-64 core.
// Inserts a NOP bubble on load/use or mispredicted JXX and counts bubbles (saturating).
module ereg_ctrl #(
  parameter int         DATA_W   = 64,
  parameter int         CNT_W    = 32,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        D_stat_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] fwdA_valA_i,
  input  logic [DATA_W-1:0] fwdB_valB_i,
  input  logic [3:0]        d_dstE_i,
  input  logic [3:0]        d_dstM_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  input  logic              e_Cnd_i,
  output logic [3:0]        E_stat_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [DATA_W-1:0] E_valC_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o,
  output logic [3:0]        E_dstE_o,
  output logic [3:0]        E_dstM_o,
  output logic [3:0]        E_srcA_o,
  output logic [3:0]        E_srcB_o,
  output logic              load_use_o,
  output logic              mispredict_o,
  output logic              E_bubble_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [3:0]        e_stat_r;
  logic [3:0]        e_icode_r;
  logic [3:0]        e_ifun_r;
  logic [DATA_W-1:0] e_valc_r;
  logic [DATA_W-1:0] e_vala_r;
  logic [DATA_W-1:0] e_valb_r;
  logic [3:0]        e_dste_r;
  logic [3:0]        e_dstm_r;
  logic [3:0]        e_srca_r;
  logic [3:0]        e_srcb_r;
  logic              e_bubble_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  logic              load_use_s;
  logic              mispredict_s;
  logic              bubble_s;
  logic [CNT_W-1:0]  cnt_next_s;

  // Hazard detection from the instruction currently held in E
  always_comb begin
    load_use_s   = 1'b0;
    mispredict_s = 1'b0;
    if (((e_icode_r == I_MRMOVQ) || (e_icode_r == I_POPQ)) && (e_dstm_r != REG_NONE) &&
        ((e_dstm_r == d_srcA_i) || (e_dstm_r == d_srcB_i))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
    if ((e_icode_r == I_JXX) && !e_Cnd_i) begin
      mispredict_s = 1'b1;
    end else begin
      mispredict_s = 1'b0;
    end
    bubble_s = load_use_s | mispredict_s;
  end

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  always_comb begin
    cnt_next_s = bubble_cnt_r;
    if (&bubble_cnt_r) begin
      cnt_next_s = bubble_cnt_r;
    end else begin
      cnt_next_s = bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // E pipeline register: reset and hazards load the bubble, otherwise capture D
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_s) begin
      e_stat_r  <= STAT_AOK;
      e_icode_r <= I_NOP;
      e_ifun_r  <= 4'h0;
      e_valc_r  <= {DATA_W{1'b0}};
      e_vala_r  <= {DATA_W{1'b0}};
      e_valb_r  <= {DATA_W{1'b0}};
      e_dste_r  <= REG_NONE;
      e_dstm_r  <= REG_NONE;
      e_srca_r  <= REG_NONE;
      e_srcb_r  <= REG_NONE;
    end else begin
      e_stat_r  <= D_stat_i;
      e_icode_r <= D_icode_i;
      e_ifun_r  <= D_ifun_i;
      e_valc_r  <= D_valC_i;
      e_vala_r  <= fwdA_valA_i;
      e_valb_r  <= fwdB_valB_i;
      e_dste_r  <= d_dstE_i;
      e_dstm_r  <= d_dstM_i;
      e_srca_r  <= d_srcA_i;
      e_srcb_r  <= d_srcB_i;
    end
  end

  // Bubble flag and performance counter; reset dominates a pending hazard
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_bubble_r   <= 1'b0;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (bubble_s) begin
      e_bubble_r   <= 1'b1;
      bubble_cnt_r <= cnt_next_s;
    end else begin
      e_bubble_r   <= 1'b0;
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign E_stat_o     = e_stat_r;
  assign E_icode_o    = e_icode_r;
  assign E_ifun_o     = e_ifun_r;
  assign E_valC_o     = e_valc_r;
  assign E_valA_o     = e_vala_r;
  assign E_valB_o     = e_valb_r;
  assign E_dstE_o     = e_dste_r;
  assign E_dstM_o     = e_dstm_r;
  assign E_srcA_o     = e_srca_r;
  assign E_srcB_o     = e_srcb_r;
  assign E_bubble_o   = e_bubble_r;
  assign bubble_cnt_o = bubble_cnt_r;
  assign load_use_o   = load_use_s;
  assign mispredict_o = mispredict_s;

endmodule
